// File: rtl/counter_pkg.sv
// Constants shared by the counter control front end and counter_div.
package counter_pkg;
   localparam int BCD_WIDTH = 4;
   localparam logic [BCD_WIDTH-1:0] BCD_MAX = 4'd9;
   localparam logic UP_DOWN_RST = 1'b1;
   localparam logic ENABLE_RST  = 1'b0;

   localparam int NUM_BTN  = 3;
   localparam int IDX_RUN  = 0;
   localparam int IDX_DIR  = 1;
   localparam int IDX_LOAD = 2;

   function automatic logic [BCD_WIDTH-1:0] bcd_clamp(input logic [BCD_WIDTH-1:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction
endpackage

// File: rtl/counter_ctrl_in_debounce.sv
// One button channel: synchroniser, stability counter, debounced level and press pulse.
module debounce
   import counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [SYNC_STAGES-1:0] sync_pipe;
   logic [CW-1:0]          cnt;
   logic                   sample;

   assign sample = sync_pipe[SYNC_STAGES-1];

   // press is raised on the very edge the level rises so the top sees it one edge later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_pipe <= '0;
         cnt       <= '0;
         level     <= 1'b0;
         press     <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], raw};
         press     <= 1'b0;
         if (sample == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES-1)) begin
            cnt   <= '0;
            level <= ~level;
            press <= ~level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/counter_ctrl_in.sv
// Button/switch conditioning for counter_div: toggled enable/up_down, load strobe and data.
// Build option: DATA_CLAMP_EN limits the loaded value to BCD_MAX.
module counter_ctrl_in
   import counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_run,
   input  logic                 btn_dir,
   input  logic                 btn_load,
   input  logic [BCD_WIDTH-1:0] sw_data,
   output logic                 enable,
   output logic                 up_down,
   output logic                 load,
   output logic [BCD_WIDTH-1:0] data_in
);
   logic [NUM_BTN-1:0] btn;
   logic [NUM_BTN-1:0] press;
   // debounced levels are not needed here; only press edges drive the controls
   logic [NUM_BTN-1:0] level_unused;

   logic [SYNC_STAGES-1:0][BCD_WIDTH-1:0] sw_pipe;
   logic [BCD_WIDTH-1:0]                  sw_sync;
   logic [BCD_WIDTH-1:0]                  load_val;

   assign btn     = {btn_load, btn_dir, btn_run};
   assign sw_sync = sw_pipe[SYNC_STAGES-1];

   debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_db [NUM_BTN-1:0] (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn),
      .level(level_unused),
      .press(press)
   );

`ifdef DATA_CLAMP_EN
   assign load_val = bcd_clamp(sw_sync);
`else
   assign load_val = sw_sync;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_pipe <= '0;
         enable  <= ENABLE_RST;
         up_down <= UP_DOWN_RST;
         load    <= 1'b0;
         data_in <= '0;
      end else begin
         sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], sw_data};
         load    <= press[IDX_LOAD];
         if (press[IDX_RUN])  enable  <= ~enable;
         if (press[IDX_DIR])  up_down <= ~up_down;
         if (press[IDX_LOAD]) data_in <= load_val;
      end
   end
endmodule

// File: tb/tb_counter_ctrl_in.sv
// Scoreboard bench for counter_ctrl_in: per-edge expected outputs from a sample-history model.
module tb_counter_ctrl_in;
   localparam int DC   = 4;
   localparam int SYNC = 2;

   typedef struct packed {
      logic       en;
      logic       ud;
      logic       ld;
      logic [3:0] d;
   } out_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_run = 1'b0, btn_dir = 1'b0, btn_load = 1'b0;
   logic [3:0] sw_data = 4'd0;
   logic       enable, up_down, load;
   logic [3:0] data_in;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   out_t       exp_q[$];
   logic [3:0] load_q[$];

   // model state: every raw sample since the last reset
   logic [2:0] rawh[$];
   logic [3:0] swh[$];
   bit   [2:0] lvl, pend;
   out_t       m;

   counter_ctrl_in #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .btn_run(btn_run), .btn_dir(btn_dir), .btn_load(btn_load),
      .sw_data(sw_data), .enable(enable), .up_down(up_down), .load(load), .data_in(data_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic [3:0] clampf(input logic [3:0] s);
`ifdef DATA_CLAMP_EN
      return (s > 4'd9) ? 4'd9 : s;
`else
      return s;
`endif
   endfunction

   // value the debouncer observes at edge e (1-based since reset)
   function automatic bit seen(input int b, input int e);
      int idx = e - 1 - SYNC;
      return (idx >= 0) ? rawh[idx][b] : 1'b0;
   endfunction

   function automatic logic [3:0] sw_seen(input int e);
      int idx = e - 1 - SYNC;
      return (idx >= 0) ? swh[idx] : 4'd0;
   endfunction

   task automatic model_reset();
      rawh.delete(); swh.delete();
      lvl = '0; pend = '0;
      m = '{en: 1'b0, ud: 1'b1, ld: 1'b0, d: 4'd0};
   endtask

   // A level flips once DC consecutive observed samples all disagree with it;
   // a rising flip becomes an output event on the following edge.
   task automatic model_edge(input logic [2:0] b, input logic [3:0] s);
      int k;
      bit stable;
      rawh.push_back(b); swh.push_back(s);
      k = rawh.size();
      m.ld = pend[2];
      if (pend[0]) m.en = ~m.en;
      if (pend[1]) m.ud = ~m.ud;
      if (pend[2]) begin
         m.d = clampf(sw_seen(k));
         load_q.push_back(m.d);
      end
      for (int i = 0; i < 3; i++) begin
         stable = (k >= DC);
         for (int j = 0; j < DC; j++)
            if (stable && seen(i, k - j) == lvl[i]) stable = 1'b0;
         pend[i] = stable && !lvl[i];
         if (stable) lvl[i] = ~lvl[i];
      end
      exp_q.push_back(m);
   endtask

   task automatic step(input logic [2:0] b, input logic [3:0] s);
      @(negedge clk);
      {btn_load, btn_dir, btn_run} = b;
      sw_data = s;
      model_edge(b, s);
   endtask

   task automatic hold(input int n, input logic [2:0] b, input logic [3:0] s);
      for (int i = 0; i < n; i++) step(b, s);
   endtask

   // asynchronous reset asserted mid-cycle, outputs checked before any clock edge
   task automatic do_reset(input int cycles, input string nm);
      @(posedge clk); #3;
      chk_on = 1'b0;
      rst = 1'b0;
      #1;
      chk({nm, "_enable"}, 8'(enable), 8'd0);
      chk({nm, "_up_down"}, 8'(up_down), 8'd1);
      chk({nm, "_load"}, 8'(load), 8'd0);
      chk({nm, "_data_in"}, 8'(data_in), 8'd0);
      repeat (cycles) @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      exp_q.delete(); load_q.delete();
      chk_on = 1'b1;
   endtask

   // monitor: one expected record per edge, plus a data check whenever load is presented
   initial begin : monitor
      out_t e;
      forever begin
         @(posedge clk); #2;
         if (chk_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("enable", 8'(enable), 8'(e.en));
            chk("up_down", 8'(up_down), 8'(e.ud));
            chk("load", 8'(load), 8'(e.ld));
            chk("data_in", 8'(data_in), 8'(e.d));
         end
         if (chk_on && load === 1'b1) begin
            if (load_q.size() == 0) chk("load_unexpected", 8'd1, 8'd0);
            else chk("load_data", 8'(data_in), 8'(load_q.pop_front()));
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit [2:0] cur;
      int       rem[3];
      logic [3:0] sw;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset(2, "rst_init");
      hold(20, 3'b000, 4'd0);
      // clean run press, release, press again
      hold(12, 3'b001, 4'd0);
      hold(6, 3'b000, 4'd0);
      hold(12, 3'b001, 4'd0);
      hold(8, 3'b000, 4'd0);
      // bouncing dir button, then stable high
      for (int i = 0; i < 10; i++) hold(2, (i % 2 == 0) ? 3'b010 : 3'b000, 4'd0);
      hold(12, 3'b010, 4'd0);
      hold(8, 3'b000, 4'd0);
      // load held long, switches moving while held
      hold(15, 3'b100, 4'd6);
      hold(15, 3'b100, 4'd3);
      hold(8, 3'b000, 4'd3);
      // out-of-range switch value
      hold(10, 3'b100, 4'd10);
      hold(8, 3'b000, 4'd10);
      // all three on the same edge
      hold(12, 3'b111, 4'd15);
      hold(8, 3'b000, 4'd15);
      // reset in the middle of a run debounce, button still held afterwards
      hold(4, 3'b001, 4'd0);
      do_reset(3, "rst_mid");
      hold(12, 3'b001, 4'd0);
      hold(8, 3'b000, 4'd0);
      // random independent button segments, occasional switch changes
      cur = '0; sw = 4'd0;
      for (int i = 0; i < 3; i++) rem[i] = 0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (rem[i] == 0) begin
               cur[i] = ~cur[i];
               rem[i] = $urandom_range(1, 12);
            end
            rem[i]--;
         end
         if ($urandom_range(0, 5) == 0) sw = 4'($urandom);
         step(cur, sw);
      end
      hold(12, 3'b000, sw);
      @(posedge clk); #3;
      chk_on = 1'b0;
      chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
      chk("load_q_drained", 8'(load_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
